// File: rtl/clint.sv
// Core-local interruptor: free-running mtime with prescaler, mtimecmp, msip,
// and a single-outstanding request/response register port.
module clint #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] i_pending,
  output logic [63:0] mtime
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        mtip_q, mtip_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;

  logic        tick;
  logic        accept;
  logic        sel_msip, sel_cmp, sel_time, hit;
  logic [63:0] mtime_wr, mtimecmp_wr;

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign tick      = (div_cnt_q == DIV_LAST);

  // Full 16-bit compares also reject misaligned offsets inside a register.
  assign sel_msip = (req_addr == 16'h0000);
  assign sel_cmp  = (req_addr == 16'h4000);
  assign sel_time = (req_addr == 16'hBFF8);
  assign hit      = sel_msip || sel_cmp || sel_time;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      assign mtime_wr[gi*8 +: 8]    = req_wstrb[gi] ? req_wdata[gi*8 +: 8] : mtime_q[gi*8 +: 8];
      assign mtimecmp_wr[gi*8 +: 8] = req_wstrb[gi] ? req_wdata[gi*8 +: 8] : mtimecmp_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    div_cnt_d   = tick ? 16'd0 : div_cnt_q + 16'd1;
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    // MTIP compares the registered values, so it trails any update by one edge.
    mtip_d      = (mtime_q >= mtimecmp_q);

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !hit;
      rsp_rdata_d = 64'd0;
      if (req_we) begin
        if (sel_time)                 mtime_d    = mtime_wr;
        if (sel_cmp)                  mtimecmp_d = mtimecmp_wr;
        if (sel_msip && req_wstrb[0]) msip_d     = req_wdata[0];
      end else begin
        if (sel_msip)      rsp_rdata_d = {63'd0, msip_q};
        else if (sel_cmp)  rsp_rdata_d = mtimecmp_q;
        else if (sel_time) rsp_rdata_d = mtime_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      mtip_q      <= 1'b0;
      div_cnt_q   <= 16'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      mtip_q      <= mtip_d;
      div_cnt_q   <= div_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign i_pending = {8'd0, mtip_q, 3'd0, msip_q, 3'd0};
  assign mtime     = mtime_q;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: register-access vector table plus hand-written
// sequences for MTIP timing, wrap, prescaler phase, backpressure and reset.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_ready;

  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata, mtime;
  logic [15:0] i_pending;

  logic        req_ready4, rsp_valid4, rsp_err4;
  logic [63:0] rsp_rdata4, mtime4;
  logic [15:0] i_pending4;

  always #5 clk = ~clk;

  clint #(.TICK_DIV(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .i_pending(i_pending), .mtime(mtime)
  );

  clint #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready4), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata4),
    .rsp_err(rsp_err4), .i_pending(i_pending4), .mtime(mtime4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // following the accept edge, with the request withdrawn.
  task automatic access(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wstrb, output logic [63:0] rdata, output logic err);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    #1;
    check("req_ready", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rsp_valid", rsp_valid, 1'b1);
    rdata = rsp_rdata;
    err   = rsp_err;
    $display("txn we=%0d addr=%h wdata=%h wstrb=%h -> rdata=%h err=%0d ipend=%h",
             we, addr, wdata, wstrb, rdata, err, i_pending);
  endtask

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic [15:0] exp_ipend;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  logic [63:0] rd, m, exp_v;
  logic        er;
  int          wait_cnt;

  initial begin
    vecs[0]  = '{1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 16'h0000, 64'd1, 8'h01, 64'd0, 1'b0, 16'h0008};
    vecs[2]  = '{1'b1, 16'h0000, 64'd0, 8'h00, 64'd0, 1'b0, 16'h0008};
    vecs[3]  = '{1'b0, 16'h0000, 64'd0, 8'h00, 64'd1, 1'b0, 16'h0008};
    vecs[4]  = '{1'b1, 16'h0000, 64'd0, 8'h01, 64'd0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 16'h0000, 64'd0, 8'h00, 64'd0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'h0F, 64'd0, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 16'h4000, 64'd0, 8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 16'h0010, 64'd0, 8'h00, 64'd0, 1'b1, 16'h0000};
    vecs[9]  = '{1'b1, 16'h4004, 64'd0, 8'hFF, 64'd0, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 16'h4000, 64'd0, 8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 16'h1234, 64'd0, 8'h00, 64'd0, 1'b1, 16'h0000};
    vecs[12] = '{1'b1, 16'h0001, 64'd1, 8'h01, 64'd0, 1'b1, 16'h0000};
    vecs[13] = '{1'b0, 16'h0000, 64'd0, 8'h00, 64'd0, 1'b0, 16'h0000};
    vecs[14] = '{1'b1, 16'h0008, 64'd1, 8'hFF, 64'd0, 1'b1, 16'h0000};
    vecs[15] = '{1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b0, 16'h0000};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and free-running count.
    repeat (10) @(negedge clk);
    check("idle_mtime", mtime, 64'd10);
    check("idle_ipend", i_pending, 16'h0000);
    check("idle_rsp_valid", rsp_valid, 1'b0);
    check("idle_rsp_rdata", rsp_rdata, 64'd0);
    check("idle_rsp_err", rsp_err, 1'b0);
    access(1'b0, 16'h4000, 64'd0, 8'h00, rd, er);
    check("rst_cmp_rdata", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_cmp_err", er, 1'b0);

    // mtime read returns the pre-tick value of the accept edge.
    m = mtime;
    access(1'b0, 16'hBFF8, 64'd0, 8'h00, rd, er);
    check("mtime_read", rd, m);
    check("mtime_after_read", mtime, m + 64'd1);

    // MTIP rises one cycle after mtime reaches mtimecmp.
    access(1'b1, 16'h4000, 64'd20, 8'hFF, rd, er);
    wait_cnt = 0;
    while (mtime != 64'd20 && wait_cnt < 100) begin
      check("mtip_below_cmp", i_pending[7], 1'b0);
      @(negedge clk);
      wait_cnt++;
    end
    check("mtime_reach_20", mtime, 64'd20);
    check("mtip_at_20", i_pending[7], 1'b0);
    @(negedge clk);
    check("mtip_after_20", i_pending, 16'h0080);
    access(1'b1, 16'h4000, 64'd1000, 8'hFF, rd, er);
    check("mtip_hold_after_cmp_wr", i_pending[7], 1'b1);
    @(negedge clk);
    check("mtip_fall", i_pending[7], 1'b0);

    // Register map, byte enables and error responses.
    for (int i = 0; i < NV; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      check($sformatf("vec%0d_ipend", i), i_pending, vecs[i].exp_ipend);
    end

    // Partial mtime write: unwritten bytes kept, no increment that cycle.
    access(1'b1, 16'hBFF8, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er);
    check("mtime_full_wr", mtime, 64'h0123_4567_89AB_CDEF);
    m = mtime;
    access(1'b1, 16'hBFF8, 64'hFFEE_DDCC_0000_0000, 8'hF0, rd, er);
    exp_v = {32'hFFEE_DDCC, m[31:0]};
    check("mtime_part_wr", mtime, exp_v);

    // Wrap at 2^64; MTIP fires on the all-ones value against all-ones cmp.
    access(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
    check("wrap_load", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    check("wrap_ff", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_ff_ipend", i_pending, 16'h0000);
    @(negedge clk);
    check("wrap_zero", mtime, 64'd0);
    check("wrap_zero_ipend", i_pending, 16'h0080);
    @(negedge clk);
    check("wrap_one_ipend", i_pending, 16'h0000);

    // Backpressure: response frozen, next request queued.
    rsp_ready = 1'b0;
    m = mtime;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hBFF8; req_wstrb = 8'h00;
    @(posedge clk);
    @(negedge clk);
    req_addr = 16'h4000;
    check("bp_rsp_valid", rsp_valid, 1'b1);
    check("bp_rdata", rsp_rdata, m);
    check("bp_req_ready", req_ready, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("bp_rdata_hold", rsp_rdata, m);
      check("bp_req_ready_hold", req_ready, 1'b0);
    end
    check("bp_mtime_counts", mtime, m + 64'd4);
    rsp_ready = 1'b1;
    #1;
    check("bp_req_ready_release", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_q_rsp_valid", rsp_valid, 1'b1);
    check("bp_q_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    check("bp_q_err", rsp_err, 1'b0);

    // Reset while a response is pending drops it.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstx_rsp_valid_pre", rsp_valid, 1'b1);
    rst = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rstx_rsp_valid", rsp_valid, 1'b0);
    check("rstx_rdata", rsp_rdata, 64'd0);
    check("rstx_mtime", mtime, 64'd0);
    check("rstx_ipend", i_pending, 16'h0000);
    check("rstx_mtime4", mtime4, 64'd0);
    rst = 1'b0;

    // TICK_DIV=4: ticks every 4th edge; an mtime write on a tick edge wins
    // and the prescaler phase is unchanged.
    repeat (3) @(negedge clk);
    check("div4_before_tick", mtime4, 64'd0);
    @(negedge clk);
    check("div4_first_tick", mtime4, 64'd1);
    repeat (3) @(negedge clk);
    check("div4_hold", mtime4, 64'd1);
    access(1'b1, 16'hBFF8, 64'd100, 8'hFF, rd, er);
    check("div4_wr_priority", mtime4, 64'd100);
    repeat (3) @(negedge clk);
    check("div4_no_early_tick", mtime4, 64'd100);
    @(negedge clk);
    check("div4_phase_kept", mtime4, 64'd101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
